// File: rtl/riscv_32i_defs_pkg.sv
// riscv_32i_defs_pkg: shared ALU types, op encodings and the ALU arbiter FSM state type.
package riscv_32i_defs_pkg;
    typedef logic [3:0] alu_op_t;
    typedef logic [31:0] word_t;
    localparam alu_op_t ALU_ADD  = 4'd0;
    localparam alu_op_t ALU_SUB  = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_SLL  = 4'd5;
    localparam alu_op_t ALU_SRL  = 4'd6;
    localparam alu_op_t ALU_SRA  = 4'd7;
    localparam alu_op_t ALU_SLT  = 4'd8;
    localparam alu_op_t ALU_SLTU = 4'd9;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr (wrapping); one-hot grant plus index.
// ALU_ARB_FIXED_PRIO_EN: ptr is ignored and the lowest requesting index always wins.
module rr_arbiter
    import riscv_32i_defs_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] base;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign base = '0;
`else
    assign base = ptr;
`endif
    // Scan offsets from farthest to nearest so the nearest requester is assigned last and wins.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ID_W'((int'(base) + k) % NUM_REQ)]) idx = ID_W'((int'(base) + k) % NUM_REQ);
        end
        grant = (|req) ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external ALU among NUM_REQ requesters, one op in flight.
// ALU_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round robin.
module alu_share_arbiter
    import riscv_32i_defs_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*4-1:0] req_op,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           alu_op,
    output logic [31:0]          alu_in_a,
    output logic [31:0]          alu_in_b,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    output logic                 busy
);
    arb_state_t          state;
    alu_op_t             op;
    word_t               a, b;
    logic [ID_W-1:0]     ptr, gidx;
    logic [NUM_REQ-1:0]  grant;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx)
    );
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RESP;
    assign alu_op    = op;
    assign alu_in_a  = a;
    assign alu_in_b  = b;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= ALU_ADD;
            a          <= '0;
            b          <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    op     <= req_op[{gidx, 2'b00} +: 4];
                    a      <= req_a[{gidx, 5'b00000} +: 32];
                    b      <= req_b[{gidx, 5'b00000} +: 32];
                    rsp_id <= gidx;
                    state  <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (state == IDLE && |req_valid) ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized transaction-level check of alu_share_arbiter against a reference model.
// Honours ALU_ARB_FIXED_PRIO_EN so the same bench covers both arbitration modes.
module tb_alu_share_arbiter;
    import riscv_32i_defs_pkg::*;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] rv;
    logic [3:0] rop[N];
    logic [31:0] ra[N], rb[N];
    logic [N*4-1:0] op_v;
    logic [N*32-1:0] a_v, b_v;
    logic [N-1:0] req_ready;
    logic rsp_valid, rsp_ready, rsp_zero, busy, alu_zero;
    logic [31:0] rsp_result, alu_in_a, alu_in_b, alu_result;
    logic [1:0] rsp_id;
    logic [3:0] alu_op;
    int checks = 0, errors = 0, mptr = 0;
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign op_v[i*4 +: 4]  = rop[i];
        assign a_v[i*32 +: 32] = ra[i];
        assign b_v[i*32 +: 32] = rb[i];
    end
    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] x, logic [31:0] y);
        case (op)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
            ALU_SLT:  return {31'd0, $signed(x) < $signed(y)};
            ALU_SLTU: return {31'd0, x < y};
            default:  return 32'd0;
        endcase
    endfunction
    // The bench plays the external ALU.
    assign alu_result = ref_alu(alu_op, alu_in_a, alu_in_b);
    assign alu_zero   = alu_result == 32'd0;
    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready),
        .req_op(op_v), .req_a(a_v), .req_b(b_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_id(rsp_id), .alu_op(alu_op),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_result(alu_result),
        .alu_zero(alu_zero), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int pick();
        for (int k = 0; k < N; k++) if (rv[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction
    task automatic new_req(input int i, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        rv[i] = 1'b1; rop[i] = op; ra[i] = x; rb[i] = y;
    endtask
    task automatic rand_req(input int i);
        logic [31:0] x;
        x = $urandom;
        new_req(i, 4'($urandom_range(0, 15)), x, ($urandom % 4 == 0) ? x : $urandom);
    endtask
    // Called just after a negedge with at least one request driven; returns at a negedge in IDLE.
    task automatic run_txn(input int hold, input bit refill);
        int g;
        logic [N-1:0] eg;
        logic [31:0] er;
        g = pick();
        eg = '0;
        eg[g] = 1'b1;
        er = ref_alu(rop[g], ra[g], rb[g]);
        #1 chk("grant", 32'(req_ready), 32'(eg));
        chk("idle_busy", 32'(busy), 0);
        @(posedge clk);
`ifndef ALU_ARB_FIXED_PRIO_EN
        mptr = (g + 1) % N;
`endif
        @(negedge clk);
        if (refill) rand_req(g); else rv[g] = 1'b0;
        rsp_ready = 1'($urandom % 2);
        #1 chk("exec_busy", 32'(busy), 1);
        chk("exec_ready", 32'(req_ready), 0);
        chk("exec_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rsp_ready = (hold == 0);
        #1 chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", 32'(rsp_zero), 32'(er == 0));
        chk("rsp_id", 32'(rsp_id), 32'(g));
        chk("rsp_ready_out", 32'(req_ready), 0);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            rsp_ready = (i == hold);
            #1 chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_result", rsp_result, er);
            chk("hold_id", 32'(rsp_id), 32'(g));
            chk("hold_busy", 32'(busy), 1);
            chk("hold_ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        #1 chk("ret_busy", 32'(busy), 0);
        chk("ret_valid", 32'(rsp_valid), 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        rv = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin rop[i] = '0; ra[i] = '0; rb[i] = '0; end
        repeat (2) @(negedge clk);
        rv = 4'b0001;
        #1 chk("rst_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        rv = '0;
        #1 chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_zero", 32'(rsp_zero), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
        chk("rst_alu_a", alu_in_a, 0);
        // Single ADD 5+7 from requester 0.
        new_req(0, ALU_ADD, 32'd5, 32'd7);
        run_txn(0, 1'b0);
        // Abort an op in EXEC with reset; pointer must return to 0.
        new_req(0, ALU_XOR, 32'h1234, 32'h00ff);
        #1 chk("abort_grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        rv = '0;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        #1 chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(rsp_valid), 0);
        chk("abort_result", rsp_result, 0);
        @(negedge clk);
        #1 chk("abort_no_rsp", 32'(rsp_valid), 0);
        // Two SUBs contending, second one held in RESP for 5 cycles.
        new_req(0, ALU_SUB, 32'd3, 32'd1);
        new_req(1, ALU_SUB, 32'd9, 32'd9);
        run_txn(0, 1'b0);
        run_txn(5, 1'b0);
        // Undefined op.
        new_req(2, 4'hF, 32'hFFFF_FFFF, 32'd1);
        run_txn(1, 1'b0);
        repeat (3) begin
            #1 chk("idle_ready", 32'(req_ready), 0);
            chk("idle_busy2", 32'(busy), 0);
            @(negedge clk);
        end
        // All requesters valid continuously from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mptr = 0;
        for (int i = 0; i < N; i++) rand_req(i);
        repeat (5) run_txn($urandom % 2, 1'b1);
        rv = '0;
        @(negedge clk);
        repeat (60) begin
            for (int i = 0; i < N; i++) if (!rv[i] && $urandom % 3 == 0) rand_req(i);
            if (rv == '0) begin
                #1 chk("rand_idle", 32'(req_ready), 0);
                @(negedge clk);
            end else begin
                run_txn($urandom % 3, 1'b0);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
